// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers a mono sample stream and serialises it onto a Philips-I2S link
// Ports: clk, reset (sync, active-high); sample_valid/sample input strobe and data;
//   i2s_bclk/i2s_lrclk/i2s_sdata serial link (mono duplicated into both slots);
//   underrun/overrun one-cycle event pulses;
//   underrun_count/overrun_count saturating event counters, only with I2S_TX_STATUS_EN defined.
module i2s_sample_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    underrun,
    output logic                    overrun
`ifdef I2S_TX_STATUS_EN
    ,
    output logic [15:0]             underrun_count,
    output logic [15:0]             overrun_count
`endif
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [BW-1:0] LAST = BW'(2 * SLOT_WIDTH - 1);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [BW-1:0] bit_cnt, bit_n, pos;
    logic [SAMPLE_WIDTH-1:0] pending, pending_n, frame_sample, frame_n, shifted;
    logic fe, load;
    always_comb begin
        fe = div_cnt == DW'(BCLK_DIV - 1);
        div_n = fe ? '0 : div_cnt + DW'(1);
        load = fe && bit_cnt == LAST;
        bit_n = fe ? (load ? '0 : bit_cnt + BW'(1)) : bit_cnt;
        pos = int'(bit_n) >= SLOT_WIDTH ? bit_n - BW'(SLOT_WIDTH) : bit_n;
        // A frame load takes the old pending value; a same-cycle sample refills pending.
        frame_n = load && state == FULL ? pending : frame_sample;
        // Positions past the sample width shift everything out, yielding zero padding.
        shifted = frame_n << pos;
        state_n = sample_valid ? FULL : load ? EMPTY : state;
        pending_n = sample_valid ? sample : pending;
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            pending      <= '0;
            frame_sample <= '0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            div_cnt      <= div_n;
            bit_cnt      <= bit_n;
            pending      <= pending_n;
            frame_sample <= frame_n;
            i2s_bclk     <= int'(div_n) >= BCLK_DIV / 2;
            underrun     <= load && state == EMPTY;
            overrun      <= sample_valid && state == FULL && !load;
            if (fe) begin
                // Word select leads the slot MSB by one bit period.
                i2s_lrclk <= bit_n != LAST && int'(bit_n) + 1 >= SLOT_WIDTH;
                i2s_sdata <= shifted[SAMPLE_WIDTH-1];
            end
        end
    end
`ifdef I2S_TX_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
            overrun_count  <= '0;
        end else begin
            if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
            if (overrun && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: random stimulus against a time-arithmetic I2S model plus literal pins
module tb_i2s_sample_tx;
    localparam int SW = 16;
    localparam int SL = 32;
    localparam int DIV = 4;
    localparam int FR = DIV * 2 * SL;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun;
`ifdef I2S_TX_STATUS_EN
    logic [15:0] underrun_count, overrun_count;
`endif
    int checks = 0;
    int errors = 0;
    int ur_seen = 0;
    int or_seen = 0;
    int cyc = 0;
    bit m_full = 0;
    bit m_ur = 0;
    bit m_or = 0;
    logic [SW-1:0] m_pend = '0;
    logic [SW-1:0] m_frame = '0;

    i2s_sample_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .underrun(underrun), .overrun(overrun)
`ifdef I2S_TX_STATUS_EN
        , .underrun_count(underrun_count), .overrun_count(overrun_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: cyc counts clk edges since reset; frames are FR edges long and load at each multiple.
    always @(posedge clk) begin
        bit load;
        if (reset) begin
            cyc = 0; m_full = 0; m_pend = '0; m_frame = '0; m_ur = 0; m_or = 0;
        end else begin
            load = ((cyc + 1) % FR) == 0;
            m_ur = load && !m_full;
            m_or = sample_valid && m_full && !load;
            if (load && m_full) begin
                m_frame = m_pend;
                m_full = 0;
            end
            if (sample_valid) begin
                m_pend = sample;
                m_full = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int b, p;
        b = (cyc / DIV) % (2 * SL);
        p = b % SL;
        chk("bclk", 64'(i2s_bclk), 64'((cyc % DIV) >= DIV / 2));
        chk("lrclk", 64'(i2s_lrclk), 64'(((b + 1) % (2 * SL)) >= SL));
        chk("sdata", 64'(i2s_sdata), 64'(p < SW ? m_frame[SW-1-p] : 1'b0));
        chk("underrun", 64'(underrun), 64'(m_ur));
        chk("overrun", 64'(overrun), 64'(m_or));
        if (underrun) ur_seen++;
        if (overrun) or_seen++;
    end

    task automatic send(input logic [SW-1:0] v);
        sample_valid = 1'b1;
        sample = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i <= FR; i++) begin
            if (cyc % FR == ph) return;
            @(negedge clk);
        end
        chk("wait_phase_timeout", 64'(cyc % FR), 64'(ph));
    endtask

    // Collects 64 bits on BCLK rising edges, starting with the bit period in which LRCLK falls.
    task automatic capture(output logic [63:0] w);
        logic pl, pb;
        int n;
        bit found;
        w = '0;
        found = 0;
        pl = i2s_lrclk;
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            if (pl && !i2s_lrclk) begin
                found = 1;
                break;
            end
            pl = i2s_lrclk;
        end
        if (!found) begin
            chk("lrclk_fall_timeout", 64'(0), 64'(1));
            return;
        end
        pb = i2s_bclk;
        n = 0;
        for (int i = 0; i < 2 * FR && n < 64; i++) begin
            @(negedge clk);
            if (!pb && i2s_bclk) begin
                w = {w[62:0], i2s_sdata};
                n++;
            end
            pb = i2s_bclk;
        end
        chk("capture_bits", 64'(n), 64'(64));
    endtask

    initial begin
        logic [63:0] w;
        logic [SW-1:0] x, y;
        int base_ur, base_or;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ur_seen = 0;
        or_seen = 0;
        repeat (300) @(negedge clk);
        chk("idle_underruns", 64'(ur_seen), 64'(1));
        chk("idle_overruns", 64'(or_seen), 64'(0));

        wait_phase($urandom_range(20, 200));
        send(16'hA5C3);
        capture(w);
        chk("a5c3_frame", w, 64'h52E18000_52E18000);
        chk("a5c3_model", 64'(m_frame), 64'(16'hA5C3));

        wait_phase(128);
        base_ur = ur_seen;
        base_or = or_seen;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom));
            repeat (FR - 1) @(negedge clk);
        end
        chk("steady_underruns", 64'(ur_seen - base_ur), 64'(0));
        chk("steady_overruns", 64'(or_seen - base_or), 64'(0));

        wait_phase(20);
        base_or = or_seen;
        send(16'h1234);
        repeat (30) @(negedge clk);
        send(16'h8000);
        capture(w);
        chk("double_overrun", 64'(or_seen - base_or), 64'(1));
        chk("newest_wins", w, 64'h40000000_40000000);

        x = 16'($urandom);
        y = 16'($urandom);
        wait_phase(100);
        send(x);
        wait_phase(FR - 1);
        base_or = or_seen;
        send(y);
        chk("coincident_old_loaded", 64'(m_frame), 64'(x));
        chk("coincident_new_pending", 64'({m_full, m_pend}), 64'({1'b1, y}));
        capture(w);
        chk("coincident_no_overrun", 64'(or_seen - base_or), 64'(0));
        chk("coincident_next_frame", w, {1'b0, y, 15'b0, 1'b0, y, 15'b0});

        wait_phase($urandom_range(150, 240));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun}), 64'(0));
`ifdef I2S_TX_STATUS_EN
        chk("reset_counters", 64'({underrun_count, overrun_count}), 64'(0));
`endif

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            send(16'($urandom));
        end
        repeat (2 * FR) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
